matmul_seq_acc: RTL and testbench
=================================

Name: matmul_seq_acc

Overview:
Parametrised sequential matrix-multiply accelerator; the next generation of the fixed 2x2 combinational top-level accelerator. Computes C = A·B for square MAT_SIZE x MAT_SIZE operand matrices using one MAC unit time-multiplexed over all products. Adds local operand/result storage, a start/busy/done handshake, and signed/unsigned mode. Sits beside core_region, driven by a memory-mapped register front-end.

Parameters:
DAT_SIZE, 8, operand element width in bits.
MAT_SIZE, 2, matrix dimension N; legal range 2..16.
ACC_WIDTH, 2*DAT_SIZE+$clog2(MAT_SIZE), result element width (derived; 17 at defaults).
ADDR_W, $clog2(MAT_SIZE*MAT_SIZE), element address width (derived).

Ports:
clk  in  1  clock; single clock domain
rst  in  1  synchronous, active-high reset
start_i  in  1  start request; accepted only in IDLE
signed_i  in  1  1 = two's-complement operands; sampled with an accepted start
accum_i  in  1  accumulate mode request; sampled with an accepted start (see Optional Feature)
a_we_i  in  1  write enable, matrix A
b_we_i  in  1  write enable, matrix B
wr_addr_i  in  ADDR_W  element address, row-major (row*N+col)
wr_data_i  in  DAT_SIZE  write data
rd_addr_i  in  ADDR_W  result read address, row-major
rd_data_o  out  ACC_WIDTH  C[rd_addr_i]; registered, 1-cycle latency
busy_o  out  1  high while computing
done_o  out  1  one-cycle completion pulse

Interface: one clock `clk`; reset `rst` is synchronous and active-high.

Behaviour:
- Reset:
  - state IDLE; busy_o=0, done_o=0, rd_data_o=0.
  - A, B, C storage and all counters cleared to 0.
  - Reset during RUN aborts immediately: no done_o pulse; C reads 0 afterwards.
- FSM states: IDLE -> RUN -> DONE -> IDLE.
  - IDLE: A/B writes accepted. start_i=1 moves to RUN and latches signed_i and accum_i.
  - RUN: busy_o=1; exactly N^3 cycles.
  - DONE: busy_o=0, done_o=1 for one cycle; returns to IDLE.
- Timing: start sampled at edge t -> busy_o high on cycles t+1 .. t+N^3 -> done_o high on cycle t+N^3+1.
- RUN sequencing:
  - Counters i (row), j (col), k (inner); k fastest, then j, then i.
  - Each cycle: prod = A[i][k]*B[k][j], extended to ACC_WIDTH (sign-extended if latched signed, else zero-extended); acc += prod.
  - On k==N-1: write C[i][j] = acc+prod (plus old C[i][j] in accumulate mode); clear acc for the next element.
  - After i=j=k=N-1 -> DONE.
- Arithmetic: modulo 2^ACC_WIDTH; no saturation. Without accumulate mode, ACC_WIDTH cannot overflow.
- Writes:
  - a_we_i/b_we_i asserted in RUN or DONE are ignored; the operands are stable for the whole computation.
  - A write on the same edge as an accepted start is committed first, and the computation uses the new value.
  - a_we_i and b_we_i together write the same address in both matrices.
- start_i in RUN or DONE is ignored; it is not queued.
- Read port:
  - Usable in any state.
  - During RUN it returns partially updated C; C is final once done_o is high.
  - Out-of-range addresses (>= N*N) return 0.

Optional Feature:
MATMUL_SEQ_ACCUM_EN.
- Defined: when accum_i is latched high, C[i][j] = C_old[i][j] + Σk A·B, modulo 2^ACC_WIDTH; when latched low, C is overwritten.
- Undefined: accum_i is ignored and C is always overwritten; no extra C read is performed during RUN.

Decomposition:
- Package matmul_seq_pkg:
  - state enum (IDLE, RUN, DONE)
  - width helper functions for ACC_WIDTH and ADDR_W
  - MAT_SIZE legality constants
- Sub-module matmul_seq_mac: DAT_SIZE x DAT_SIZE multiplier with signed/unsigned extension plus ACC_WIDTH accumulator, with clear and enable inputs.
- FSM, counters and storage stay in the top module.

Test Plan:
- Unsigned run, N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start -> busy_o high 8 cycles, done_o pulse on the 9th; C=[[19,22],[43,50]].
- Signed run, A=[[0xFF,2],[3,0xFC]], B=identity -> C=[[0x1FFFF,2],[3,0x1FFFC]]. The same run unsigned -> C=[[255,2],[3,252]].
- Max values, unsigned, all elements 255 -> every C element 130050 (0x1FC02); no wrap.
- Reset mid-run: assert rst at cycle 4 of RUN -> busy_o=0 next edge, no done_o; all C reads return 0. A fresh load and start then completes normally.
- Write and start protection: during RUN write A[0]=9 and pulse start_i -> result equals the unsigned-run result; only one done_o pulse. A second start (no reload) reproduces the same C.
- With MATMUL_SEQ_ACCUM_EN: repeat the unsigned-run case with accum_i=1 -> C=[[38,44],[86,100]]. Without the macro -> C stays [[19,22],[43,50]].

Source files
------------

// File: rtl/matmul_seq_pkg.sv
// Shared types and width helpers for the sequential matrix-multiply accelerator.
// Used by matmul_seq_acc and matmul_seq_mac.
package matmul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAT_SIZE_MIN = 2;
  localparam int MAT_SIZE_MAX = 16;

  // Worst-case dot product of N DAT-bit products needs log2(N) guard bits.
  function automatic int acc_width(input int dat_size, input int mat_size);
    return 2 * dat_size + $clog2(mat_size);
  endfunction

  function automatic int addr_width(input int mat_size);
    return $clog2(mat_size * mat_size);
  endfunction

  function automatic int cnt_width(input int mat_size);
    return (mat_size > 1) ? $clog2(mat_size) : 1;
  endfunction

endpackage

// File: rtl/matmul_seq_mac.sv
// Single multiply-accumulate unit: DAT x DAT product widened to ACC_WIDTH
// (sign- or zero-extended) plus a running accumulator with clear/enable.
module matmul_seq_mac
  import matmul_seq_pkg::*;
#(
  parameter int DAT_SIZE  = 8,
  parameter int ACC_WIDTH = acc_width(8, 2)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 signed_mode,
  input  logic [DAT_SIZE-1:0]  a,
  input  logic [DAT_SIZE-1:0]  b,
  output logic [ACC_WIDTH-1:0] sum
);

  localparam int PROD_W = 2 * DAT_SIZE + 1;

  logic signed [DAT_SIZE:0]    a_ext_p0;
  logic signed [DAT_SIZE:0]    b_ext_p0;
  logic signed [PROD_W-1:0]    prod_narrow_p0;
  logic signed [ACC_WIDTH-1:0] prod_p0;
  logic signed [ACC_WIDTH-1:0] sum_p0;
  logic signed [ACC_WIDTH-1:0] acc_p1;

  // One extra bit lets a single signed multiplier serve both modes; the exact
  // product of two such operands always fits in 2*DAT_SIZE+1 signed bits.
  function automatic logic signed [DAT_SIZE:0] extend_operand(
    input logic [DAT_SIZE-1:0] v,
    input logic                is_signed
  );
    return {is_signed & v[DAT_SIZE-1], v};
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] widen_product(
    input logic signed [PROD_W-1:0] p
  );
    return ACC_WIDTH'(p);
  endfunction

  assign a_ext_p0       = extend_operand(a, signed_mode);
  assign b_ext_p0       = extend_operand(b, signed_mode);
  assign prod_narrow_p0 = PROD_W'(a_ext_p0) * PROD_W'(b_ext_p0);
  assign prod_p0        = widen_product(prod_narrow_p0);
  assign sum_p0         = acc_p1 + prod_p0;
  assign sum            = sum_p0;

  // ---- stage p0 -> p1: running accumulator ----
  always_ff @(posedge clk) begin
    if (clr) begin
      acc_p1 <= '0;
    end else if (en) begin
      acc_p1 <= sum_p0;
    end
  end

endmodule

// File: rtl/matmul_seq_acc.sv
// Sequential N x N matrix multiplier (C = A*B) using one time-multiplexed MAC.
// Define MATMUL_SEQ_ACCUM_EN to enable accumulate-into-C mode (accum_i).
module matmul_seq_acc
  import matmul_seq_pkg::*;
#(
  parameter int DAT_SIZE  = 8,
  parameter int MAT_SIZE  = 2,
  parameter int ACC_WIDTH = acc_width(DAT_SIZE, MAT_SIZE),
  parameter int ADDR_W    = addr_width(MAT_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic                 accum_i,
  input  logic                 a_we_i,
  input  logic                 b_we_i,
  input  logic [ADDR_W-1:0]    wr_addr_i,
  input  logic [DAT_SIZE-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0]    rd_addr_i,
  output logic [ACC_WIDTH-1:0] rd_data_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int NN    = MAT_SIZE * MAT_SIZE;
  localparam int CNT_W = cnt_width(MAT_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAT_SIZE - 1);

  if (MAT_SIZE < MAT_SIZE_MIN || MAT_SIZE > MAT_SIZE_MAX) begin : g_bad_size
    $error("matmul_seq_acc: MAT_SIZE must be within 2..16");
  end

  state_t state_q, state_d;

  logic [CNT_W-1:0] i_q, j_q, k_q;
  logic             i_last, j_last, k_last;
  logic             start_ok, run, wr_ok, rd_ok;
  logic             signed_q;

  logic [DAT_SIZE-1:0]  a_mem [NN];
  logic [DAT_SIZE-1:0]  b_mem [NN];
  logic [ACC_WIDTH-1:0] c_mem [NN];

  logic [ADDR_W-1:0]    a_idx, b_idx, c_idx;
  logic [ACC_WIDTH-1:0] mac_sum, c_old, c_new;
  logic                 mac_clr;

  function automatic logic [ADDR_W-1:0] flat(
    input logic [CNT_W-1:0] r,
    input logic [CNT_W-1:0] c
  );
    return ADDR_W'(int'(r) * MAT_SIZE + int'(c));
  endfunction

  assign run      = (state_q == RUN);
  assign start_ok = (state_q == IDLE) && start_i;
  assign i_last   = (i_q == CNT_LAST);
  assign j_last   = (j_q == CNT_LAST);
  assign k_last   = (k_q == CNT_LAST);
  assign wr_ok    = (state_q == IDLE) && ({1'b0, wr_addr_i} < (ADDR_W + 1)'(NN));
  assign rd_ok    = ({1'b0, rd_addr_i} < (ADDR_W + 1)'(NN));

  assign a_idx = flat(i_q, k_q);
  assign b_idx = flat(k_q, j_q);
  assign c_idx = flat(i_q, j_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN: begin
        busy_o = 1'b1;
        if (i_last && j_last && k_last) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // k runs fastest, then j, then i; all restart on an accepted start.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (run) begin
      if (k_last) begin
        k_q <= '0;
        if (j_last) begin
          j_q <= '0;
          i_q <= i_last ? '0 : i_q + CNT_W'(1);
        end else begin
          j_q <= j_q + CNT_W'(1);
        end
      end else begin
        k_q <= k_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      signed_q <= 1'b0;
    end else if (start_ok) begin
      signed_q <= signed_i;
    end
  end

`ifdef MATMUL_SEQ_ACCUM_EN
  logic accum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      accum_q <= 1'b0;
    end else if (start_ok) begin
      accum_q <= accum_i;
    end
  end

  assign c_old = accum_q ? c_mem[c_idx] : '0;
`else
  logic accum_unused;
  assign accum_unused = accum_i;
  assign c_old        = '0;
`endif

  // The accumulator restarts at every element boundary and on a new job.
  assign mac_clr = rst || start_ok || (run && k_last);

  matmul_seq_mac #(
    .DAT_SIZE  (DAT_SIZE),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk         (clk),
    .clr         (mac_clr),
    .en          (run),
    .signed_mode (signed_q),
    .a           (a_mem[a_idx]),
    .b           (b_mem[b_idx]),
    .sum         (mac_sum)
  );

  assign c_new = mac_sum + c_old;

  // ---- storage: operands written only in IDLE, C written at each k wrap ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NN; n++) begin
        a_mem[n] <= '0;
        b_mem[n] <= '0;
        c_mem[n] <= '0;
      end
    end else begin
      if (wr_ok && a_we_i) a_mem[wr_addr_i] <= wr_data_i;
      if (wr_ok && b_we_i) b_mem[wr_addr_i] <= wr_data_i;
      if (run && k_last)   c_mem[c_idx]     <= c_new;
    end
  end

  // ---- read port: one registered stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= rd_ok ? c_mem[rd_addr_i] : '0;
    end
  end

endmodule

// File: tb/tb_matmul_seq_acc.sv
// Self-checking bench for matmul_seq_acc: directed cases from the test plan
// plus randomized runs against a behavioural matrix-product model.
module tb_matmul_seq_acc;

  localparam int DAT  = 8;
  localparam int N    = 2;
  localparam int ACC  = 2 * DAT + $clog2(N);
  localparam int AW   = $clog2(N * N);
  localparam int NN   = N * N;
  localparam int RUNC = N * N * N;
`ifdef MATMUL_SEQ_ACCUM_EN
  localparam bit ACCUM_BUILD = 1'b1;
`else
  localparam bit ACCUM_BUILD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_i = 1'b0, signed_i = 1'b0, accum_i = 1'b0;
  logic           a_we_i = 1'b0, b_we_i = 1'b0;
  logic [AW-1:0]  wr_addr_i = '0, rd_addr_i = '0;
  logic [DAT-1:0] wr_data_i = '0;
  logic [ACC-1:0] rd_data_o;
  logic           busy_o, done_o;

  int checks = 0;
  int errors = 0;

  logic [DAT-1:0] a_m [NN];
  logic [DAT-1:0] b_m [NN];
  logic [ACC-1:0] c_m [NN];

  always #5 clk = ~clk;

  matmul_seq_acc #(.DAT_SIZE(DAT), .MAT_SIZE(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .accum_i   (accum_i),
    .a_we_i    (a_we_i),
    .b_we_i    (b_we_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  // Reference: plain integer matrix product, reduced modulo 2^ACC.
  function automatic void model_run(input bit sgn, input bit acc);
    longint mask, s, av, bv;
    mask = (longint'(1) << ACC) - 1;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = (acc && ACCUM_BUILD) ? longint'(c_m[i*N+j]) : 0;
        for (int k = 0; k < N; k++) begin
          av = longint'(a_m[i*N+k]);
          bv = longint'(b_m[k*N+j]);
          if (sgn && a_m[i*N+k][DAT-1]) av = av - (longint'(1) << DAT);
          if (sgn && b_m[k*N+j][DAT-1]) bv = bv - (longint'(1) << DAT);
          s = s + av * bv;
        end
        c_m[i*N+j] = ACC'(s & mask);
      end
    end
  endfunction

  function automatic void model_clear();
    for (int n = 0; n < NN; n++) begin
      a_m[n] = '0;
      b_m[n] = '0;
      c_m[n] = '0;
    end
  endfunction

  task automatic wr_elem(input bit wa, input bit wb, input int addr, input logic [DAT-1:0] d);
    @(negedge clk);
    a_we_i = wa; b_we_i = wb; wr_addr_i = AW'(addr); wr_data_i = d;
    @(negedge clk);
    a_we_i = 1'b0; b_we_i = 1'b0;
    if (wa) a_m[addr] = d;
    if (wb) b_m[addr] = d;
  endtask

  task automatic load(input logic [DAT-1:0] av [NN], input logic [DAT-1:0] bv [NN]);
    for (int n = 0; n < NN; n++) begin
      wr_elem(1'b1, 1'b0, n, av[n]);
      wr_elem(1'b0, 1'b1, n, bv[n]);
    end
  endtask

  task automatic read_c(input int addr, output logic [ACC-1:0] d);
    @(negedge clk);
    rd_addr_i = AW'(addr);
    @(negedge clk);
    d = rd_data_o;
  endtask

  // poke: 0 none, 1 write A/B[0] and pulse start mid-run, 2 write A[0] with start.
  task automatic do_run(input bit sgn, input bit acc, input int poke, input logic [DAT-1:0] pd,
                        output int busy_cnt, output int done_cnt, output int done_pos);
    busy_cnt = 0; done_cnt = 0; done_pos = -1;
    @(negedge clk);
    start_i = 1'b1; signed_i = sgn; accum_i = acc;
    if (poke == 2) begin
      a_we_i = 1'b1; wr_addr_i = '0; wr_data_i = pd;
      a_m[0] = pd;
    end
    @(negedge clk);
    start_i = 1'b0; a_we_i = 1'b0;
    for (int c = 1; c <= RUNC + 6; c++) begin
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cnt++;
        done_pos = c;
      end
      if (poke == 1 && c == 2) begin
        a_we_i = 1'b1; b_we_i = 1'b1; start_i = 1'b1; wr_addr_i = '0; wr_data_i = pd;
      end else begin
        a_we_i = 1'b0; b_we_i = 1'b0; start_i = 1'b0;
      end
      @(negedge clk);
    end
    model_run(sgn, acc);
  endtask

  task automatic test_reset();
    logic [ACC-1:0] d;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
    checks++; if (rd_data_o !== '0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", rd_data_o); end
    rst = 1'b0;
    model_clear();
    for (int n = 0; n < NN; n++) begin
      read_c(n, d);
      checks++; if (d !== '0) begin errors++; $display("FAIL reset_c[%0d]: got %0d expected 0", n, d); end
    end
  endtask

  task automatic test_unsigned();
    logic [DAT-1:0] av [NN] = '{1, 2, 3, 4};
    logic [DAT-1:0] bv [NN] = '{5, 6, 7, 8};
    logic [ACC-1:0] exp_c [NN] = '{19, 22, 43, 50};
    logic [ACC-1:0] d;
    int bc, dc, dp;
    load(av, bv);
    do_run(1'b0, 1'b0, 0, '0, bc, dc, dp);
    checks++; if (bc != RUNC) begin errors++; $display("FAIL unsigned_busy_cycles: got %0d expected %0d", bc, RUNC); end
    checks++; if (dc != 1) begin errors++; $display("FAIL unsigned_done_count: got %0d expected 1", dc); end
    checks++; if (dp != RUNC + 1) begin errors++; $display("FAIL unsigned_done_pos: got %0d expected %0d", dp, RUNC + 1); end
    for (int n = 0; n < NN; n++) begin
      read_c(n, d);
      checks++; if (d !== exp_c[n]) begin errors++; $display("FAIL unsigned_c[%0d]: got %0d expected %0d", n, d, exp_c[n]); end
    end
  endtask

  task automatic test_accum();
    logic [ACC-1:0] exp_c [NN];
    logic [ACC-1:0] d;
    int bc, dc, dp;
    exp_c = ACCUM_BUILD ? '{38, 44, 86, 100} : '{19, 22, 43, 50};
    do_run(1'b0, 1'b1, 0, '0, bc, dc, dp);
    checks++; if (dc != 1) begin errors++; $display("FAIL accum_done_count: got %0d expected 1", dc); end
    for (int n = 0; n < NN; n++) begin
      read_c(n, d);
      checks++; if (d !== exp_c[n]) begin errors++; $display("FAIL accum_c[%0d]: got %0d expected %0d", n, d, exp_c[n]); end
    end
  endtask

  task automatic test_signed();
    logic [DAT-1:0] av [NN] = '{8'hFF, 2, 3, 8'hFC};
    logic [DAT-1:0] bv [NN] = '{1, 0, 0, 1};
    logic [ACC-1:0] exp_s [NN] = '{17'h1FFFF, 2, 3, 17'h1FFFC};
    logic [ACC-1:0] exp_u [NN] = '{255, 2, 3, 252};
    logic [ACC-1:0] d;
    int bc, dc, dp;
    load(av, bv);
    do_run(1'b1, 1'b0, 0, '0, bc, dc, dp);
    for (int n = 0; n < NN; n++) begin
      read_c(n, d);
      checks++; if (d !== exp_s[n]) begin errors++; $display("FAIL signed_c[%0d]: got %0h expected %0h", n, d, exp_s[n]); end
    end
    do_run(1'b0, 1'b0, 0, '0, bc, dc, dp);
    for (int n = 0; n < NN; n++) begin
      read_c(n, d);
      checks++; if (d !== exp_u[n]) begin errors++; $display("FAIL signed_as_unsigned_c[%0d]: got %0d expected %0d", n, d, exp_u[n]); end
    end
  endtask

  task automatic test_max();
    logic [DAT-1:0] av [NN] = '{255, 255, 255, 255};
    logic [ACC-1:0] d;
    int bc, dc, dp;
    load(av, av);
    do_run(1'b0, 1'b0, 0, '0, bc, dc, dp);
    for (int n = 0; n < NN; n++) begin
      read_c(n, d);
      checks++; if (d !== 17'd130050) begin errors++; $display("FAIL max_c[%0d]: got %0d expected 130050", n, d); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [DAT-1:0] av [NN] = '{1, 2, 3, 4};
    logic [DAT-1:0] bv [NN] = '{5, 6, 7, 8};
    logic [ACC-1:0] d;
    int bc, dc, dp, seen_done;
    load(av, bv);
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; accum_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy_o); end
    rst = 1'b0;
    model_clear();
    seen_done = 0;
    for (int c = 0; c < RUNC + 4; c++) begin
      if (done_o) seen_done++;
      @(negedge clk);
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses expected 0", seen_done); end
    for (int n = 0; n < NN; n++) begin
      read_c(n, d);
      checks++; if (d !== '0) begin errors++; $display("FAIL midreset_c[%0d]: got %0d expected 0", n, d); end
    end
    load(av, bv);
    do_run(1'b0, 1'b0, 0, '0, bc, dc, dp);
    checks++; if (dc != 1) begin errors++; $display("FAIL midreset_rerun_done: got %0d expected 1", dc); end
    for (int n = 0; n < NN; n++) begin
      read_c(n, d);
      checks++; if (d !== c_m[n]) begin errors++; $display("FAIL midreset_rerun_c[%0d]: got %0d expected %0d", n, d, c_m[n]); end
    end
  endtask

  task automatic test_protection();
    logic [ACC-1:0] d;
    int bc, dc, dp;
    do_run(1'b0, 1'b0, 1, 8'd9, bc, dc, dp);
    checks++; if (dc != 1) begin errors++; $display("FAIL protect_done_count: got %0d expected 1", dc); end
    checks++; if (bc != RUNC) begin errors++; $display("FAIL protect_busy_cycles: got %0d expected %0d", bc, RUNC); end
    for (int n = 0; n < NN; n++) begin
      read_c(n, d);
      checks++; if (d !== c_m[n]) begin errors++; $display("FAIL protect_c[%0d]: got %0d expected %0d", n, d, c_m[n]); end
    end
    do_run(1'b0, 1'b0, 0, '0, bc, dc, dp);
    for (int n = 0; n < NN; n++) begin
      read_c(n, d);
      checks++; if (d !== c_m[n]) begin errors++; $display("FAIL protect_rerun_c[%0d]: got %0d expected %0d", n, d, c_m[n]); end
    end
  endtask

  task automatic test_write_with_start();
    logic [ACC-1:0] d;
    int bc, dc, dp;
    do_run(1'b0, 1'b0, 2, 8'd7, bc, dc, dp);
    for (int n = 0; n < NN; n++) begin
      read_c(n, d);
      checks++; if (d !== c_m[n]) begin errors++; $display("FAIL wr_with_start_c[%0d]: got %0d expected %0d", n, d, c_m[n]); end
    end
  endtask

  task automatic test_random();
    logic [ACC-1:0] d;
    int bc, dc, dp;
    bit sgn, acc;
    for (int it = 0; it < 8; it++) begin
      for (int n = 0; n < NN; n++) begin
        wr_elem(1'b1, 1'b0, n, DAT'($urandom));
        wr_elem(1'b0, 1'b1, n, DAT'($urandom));
      end
      wr_elem(1'b1, 1'b1, $urandom_range(NN - 1), DAT'($urandom));
      sgn = 1'($urandom);
      acc = 1'($urandom);
      do_run(sgn, acc, 0, '0, bc, dc, dp);
      checks++; if (dp != RUNC + 1) begin errors++; $display("FAIL random%0d_done_pos: got %0d expected %0d", it, dp, RUNC + 1); end
      for (int n = 0; n < NN; n++) begin
        read_c(n, d);
        checks++; if (d !== c_m[n]) begin errors++; $display("FAIL random%0d_c[%0d]: got %0h expected %0h (signed=%0d accum=%0d)", it, n, d, c_m[n], sgn, acc); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_accum();
    test_signed();
    test_max();
    test_reset_mid_run();
    test_protection();
    test_write_with_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
